// File: rtl/shared_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : shared_pkg                                                |
// | Brief    : Types and constants shared by the GLB datapath blocks.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package shared_pkg;

    // GLB bank selector
    typedef enum logic [1:0] {
        IFMAP  = 2'd0,
        FILTER = 2'd1,
        BIAS   = 2'd2,
        PSUM   = 2'd3
    } data_t;

    // GLB word address width
    localparam int ADDR_WIDTH = 12;

    // Packed 16-bit values per 64-bit GLB/DRAM word
    localparam int DRAIN_WORD_LANES = 4;

endpackage
`default_nettype wire

// File: rtl/drain_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : drain_skid_fifo                                           |
// | Brief    : Small register FIFO that absorbs GLB read latency. The    |
// |            head entry is presented directly from storage, and a      |
// |            push and pop may happen in the same cycle even when full. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module drain_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;

    // A push while full is only honoured when the head leaves in the same cycle
    assign o_valid   = (r_count != '0);
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_do_pop  = i_pop && o_valid;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Read/write pointers wrap at DEPTH-1; occupancy tracks push minus pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared on reset so the idle head word reads as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/glb_data_drain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : glb_data_drain                                            |
// | Brief    : Reads a contiguous GLB region and streams the words out   |
// |            on a valid/ready interface toward the DRAM output FIFO.   |
// |            Reads are throttled so buffered plus in-flight words      |
// |            never exceed the skid buffer depth.                       |
// | Options  : DRAIN_RELU_EN - clamp negative 16-bit lanes of PSUM words |
// |            to zero as they enter the skid buffer.                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module glb_data_drain
    import shared_pkg::data_t;
    import shared_pkg::IFMAP;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WORD_WIDTH = 64,
    parameter int ADDR_WIDTH = shared_pkg::ADDR_WIDTH,
    parameter int SKID_DEPTH = 2
) (
    input  logic                  core_clk,
    input  logic                  core_reset,
    input  logic                  start,
    input  data_t                 data_type,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  glb_rd_en,
    output data_t                 glb_rd_type,
    output logic [ADDR_WIDTH-1:0] glb_rd_addr,
    input  logic [WORD_WIDTH-1:0] glb_rd_data,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [ADDR_WIDTH-1:0] words_sent
);

    localparam int c_CNT_W  = $clog2(SKID_DEPTH + 1);
    localparam int c_PEND_W = c_CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [c_PEND_W-1:0]   c_SKID_LIM = c_PEND_W'(SKID_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    data_t                 r_type;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_num;
    logic [ADDR_WIDTH-1:0] r_issued;
    logic [ADDR_WIDTH-1:0] r_words_sent;
    logic                  r_inflight;

    logic [ADDR_WIDTH-1:0] w_issued_next;
    logic [ADDR_WIDTH-1:0] w_sent_next;
    logic [c_CNT_W-1:0]    w_occ;
    logic [c_PEND_W-1:0]   w_pending;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_accept;
    logic [WORD_WIDTH-1:0] w_head;
    logic [WORD_WIDTH-1:0] w_push_data;

    // A read may issue only if the word it returns is guaranteed a skid slot
    assign w_pop         = w_valid && dout_ready;
    assign w_pending     = c_PEND_W'(w_occ) + c_PEND_W'(r_inflight) - c_PEND_W'(w_pop);
    assign w_issue       = (r_state == ST_READ) && (r_issued < r_num) && (w_pending < c_SKID_LIM);
    assign w_issued_next = r_issued + c_ADDR_ONE;
    assign w_sent_next   = r_words_sent + ADDR_WIDTH'(w_pop);
    assign w_accept      = (r_state == ST_IDLE) && start;

    assign glb_rd_en   = w_issue;
    assign glb_rd_addr = r_addr;
    assign glb_rd_type = r_type;
    assign dout        = w_head;
    assign dout_valid  = w_valid;
    assign words_sent  = r_words_sent;

`ifdef DRAIN_RELU_EN
    logic w_is_psum;
    assign w_is_psum = (r_type == shared_pkg::PSUM);

    for (genvar g = 0; g < shared_pkg::DRAIN_WORD_LANES; g++) begin : g_relu_lane
        logic [DATA_WIDTH-1:0] w_lane;
        assign w_lane = glb_rd_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_push_data[g*DATA_WIDTH +: DATA_WIDTH] =
            (w_is_psum && w_lane[DATA_WIDTH-1]) ? '0 : w_lane;
    end
`else
    for (genvar g = 0; g < shared_pkg::DRAIN_WORD_LANES; g++) begin : g_pass_lane
        assign w_push_data[g*DATA_WIDTH +: DATA_WIDTH] = glb_rd_data[g*DATA_WIDTH +: DATA_WIDTH];
    end
`endif

    // Read data lands one cycle after the strobe, so the push is the delayed issue
    drain_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (WORD_WIDTH)
    ) u_skid (
        .clk         (core_clk),
        .rst         (core_reset),
        .i_push      (r_inflight),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_valid),
        .o_count     (w_occ)
    );

    // FSM state register
    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and status outputs; completion uses the post-handshake count
    // so done follows the final word by exactly one cycle
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != ST_IDLE);
        done         = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE:  if (start) w_next_state = (num_words == '0) ? ST_DONE : ST_READ;
            ST_READ:  if (w_issue && (w_issued_next == r_num)) w_next_state = ST_FLUSH;
            ST_FLUSH: if (w_sent_next == r_num) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Transfer context: latched at start, then advanced per issue and handshake
    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            r_type       <= IFMAP;
            r_addr       <= '0;
            r_num        <= '0;
            r_issued     <= '0;
            r_words_sent <= '0;
            r_inflight   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_accept) begin
                r_type       <= data_type;
                r_addr       <= base_addr;
                r_num        <= num_words;
                r_issued     <= '0;
                r_words_sent <= '0;
            end else begin
                if (w_issue) begin
                    r_addr   <= r_addr + c_ADDR_ONE;
                    r_issued <= w_issued_next;
                end
                r_words_sent <= w_sent_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/glb_data_drain.md
# glb_data_drain

Streams a contiguous region of global buffer (GLB) words back toward DRAM: the readout counterpart of the DRAM-to-GLB write path. Given a data type, base address and word count, it issues GLB reads, absorbs the one-cycle SRAM read latency in a small skid buffer, and presents 64-bit words (four packed 16-bit values) on a valid/ready stream to the DRAM-side interface. It sits between the GLB read port and the DRAM output FIFO. It is used mainly to drain PSUM/ofmap results after each conv layer segment.

## Interface
- DATA_WIDTH, 16: width of one packed value.
- WORD_WIDTH, 64: GLB/DRAM word width; must equal 4*DATA_WIDTH.
- ADDR_WIDTH, shared_pkg ADDR_WIDTH: GLB word address width.
- SKID_DEPTH, 2: skid buffer entries; minimum 2 for full throughput.
- core_clk  in  1  single clock.
- core_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- data_type  in  data_t  GLB bank to read (IFMAP/FILTER/BIAS/PSUM).
- base_addr  in  ADDR_WIDTH  first word address.
- num_words  in  ADDR_WIDTH  word count; 0 allowed.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at completion.
- glb_rd_en  out  1  GLB read strobe.
- glb_rd_type  out  data_t  bank select, held for the whole transfer.
- glb_rd_addr  out  ADDR_WIDTH  read address.
- glb_rd_data  in  WORD_WIDTH  valid exactly 1 cycle after glb_rd_en.
- dout  out  WORD_WIDTH  output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts when valid&&ready.
- words_sent  out  ADDR_WIDTH  count of handshaken words in current/last transfer.

## Operation
- FSM states: IDLE, READ, FLUSH, DONE.
- IDLE: on start, latch data_type/base_addr/num_words, clear words_sent, go to READ. If num_words=0, go to DONE instead.
- READ: issue a read when issue count < num_words and (occupancy + inflight − pop) < SKID_DEPTH. pop = dout_valid&&dout_ready. The address increments by 1 per issued read and wraps modulo 2^ADDR_WIDTH. After the last issue, go to FLUSH.
- FLUSH: wait until words_sent == num_words. Then go to DONE.
- DONE: pulse done for one cycle, return to IDLE.
- Skid buffer: FIFO of SKID_DEPTH entries. It is written on the cycle after a read issue with glb_rd_data. dout/dout_valid come from its head, registered. Simultaneous push and pop is allowed at any occupancy, including full.
- start while busy: ignored. Input changes after start: ignored.
- Reset outputs: busy=0, done=0, glb_rd_en=0, glb_rd_addr=0, glb_rd_type=IFMAP, dout=0, dout_valid=0, words_sent=0. Reset mid-transfer returns to IDLE, empties the skid buffer and discards any in-flight read data. The next start is accepted cleanly.

## Timing
- Start sampled at cycle 0. The first glb_rd_en is at cycle 1, its data at cycle 2, and dout_valid at cycle 3.
- With dout_ready held high, one word is handshaken per cycle. N words: last handshake at cycle N+2, done at cycle N+3, busy low at cycle N+4.
- dout_ready low: at most SKID_DEPTH words are buffered or in flight. No word is dropped or duplicated. dout is stable while valid&&!ready.
- num_words=0: done at cycle 1, no glb_rd_en.

## Configuration
- DRAIN_RELU_EN defined: each 16-bit lane of the word written into the skid buffer is clamped to 0 if negative (signed two's complement). This applies only when the latched data_type==PSUM; other types pass unchanged.
- Not defined: all data passes bit-exact. No comparator logic is synthesized.

## Structure
- shared_pkg holds: data_t; ADDR_WIDTH; a DRAIN_WORD_LANES=4 constant.
- The FSM state enum stays local to the module.
- One sub-module: drain_skid_fifo (parameterised depth/width, push/pop/count, synchronous reset).
- The ReLU is a generate block inside glb_data_drain under DRAIN_RELU_EN.

## Test plan
- PSUM, base=0, num=8, ready=1, GLB word k = k → reads 0..7 on cycles 1..8; dout 0..7 on cycles 3..10; done at cycle 11.
- num=6 with ready toggling 1,0,0,1 repeatedly → all 6 words in order, no drops or duplicates; glb_rd_en never makes buffered + in-flight exceed 2.
- base=2^ADDR_WIDTH−2, num=4 → read addresses max−1, max, 0, 1.
- num=0 → done one cycle after start; no reads and no dout_valid.
- core_reset at cycle 5 of a 16-word transfer → outputs reach reset values next cycle; a new start with num=3 delivers exactly 3 correct words.
- DRAIN_RELU_EN with PSUM word 0xFFFF_0005_8000_7FFF → dout 0x0000_0005_0000_7FFF; the same word with FILTER passes unchanged.
